nvdla_conv_flow_ctrl: RTL and testbench

Parametrised successor to the fixed CSC→CMAC→CACC→SDP valid chain. It joins data and weight atom streams into MAC operations and groups `cfg_atoms` operations into one output stripe. Each stripe result passes through a `MAC_LAT`-deep pipeline into a credit-protected output buffer, which drains to SDP over a valid/ready handshake. It sits between the CSC sequencer outputs and the SDP input. It adds the back-pressure, channel tagging and operation completion tracking that the fixed chain lacks.

---
 rtl/nvdla_conv_pkg.sv | 22 ++
 rtl/nvdla_conv_flow_ctrl_if.sv | 23 ++
 rtl/nvdla_conv_obuf.sv | 54 +++++
 rtl/nvdla_conv_flow_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_nvdla_conv_flow_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nvdla_conv_pkg.sv
// rtl/nvdla_conv_pkg.sv - shared types and parameter defaults for the conv flow controller
package nvdla_conv_pkg;

    localparam int NUM_CH_DEF     = 2;
    localparam int MAC_LAT_DEF    = 3;
    localparam int ATOMS_W_DEF    = 8;
    localparam int STRIPES_W_DEF  = 16;
    localparam int OBUF_DEPTH_DEF = 4;
    localparam int CH_W_DEF       = (NUM_CH_DEF > 1) ? $clog2(NUM_CH_DEF) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [CH_W_DEF-1:0] ch;
        logic                last;
    } res_t;

endpackage

// File: rtl/nvdla_conv_flow_ctrl_if.sv
// rtl/nvdla_conv_flow_ctrl_if.sv - atom input and result output handshakes
interface nvdla_conv_flow_ctrl_if #(
    parameter int CH_W = 1
);
    logic            data_i_valid;
    logic            data_i_ready;
    logic            weight_i_valid;
    logic            weight_i_ready;
    logic            cacc2sdp_valid;
    logic            sdp2cacc_ready;
    logic [CH_W-1:0] cacc2sdp_ch;
    logic            cacc2sdp_last;

    modport slave (
        input  data_i_valid, weight_i_valid, sdp2cacc_ready,
        output data_i_ready, weight_i_ready, cacc2sdp_valid, cacc2sdp_ch, cacc2sdp_last
    );

    modport master (
        output data_i_valid, weight_i_valid, sdp2cacc_ready,
        input  data_i_ready, weight_i_ready, cacc2sdp_valid, cacc2sdp_ch, cacc2sdp_last
    );
endinterface

// File: rtl/nvdla_conv_obuf.sv
// rtl/nvdla_conv_obuf.sv - result FIFO with extra-MSB pointer wrap
module nvdla_conv_obuf
    import nvdla_conv_pkg::*;
#(
    parameter int  DEPTH   = OBUF_DEPTH_DEF,
    parameter type entry_t = res_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   empty,
    output logic   full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    entry_t      mem_q [DEPTH];
    entry_t      mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q[AW-1:0]] = push_data;
            wr_d                = wr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

    assign head  = mem_q[rd_q[AW-1:0]];
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/nvdla_conv_flow_ctrl.sv
// rtl/nvdla_conv_flow_ctrl.sv - joins data/weight atoms into stripes and drains tagged results to SDP
module nvdla_conv_flow_ctrl
    import nvdla_conv_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int MAC_LAT    = MAC_LAT_DEF,
    parameter int ATOMS_W    = ATOMS_W_DEF,
    parameter int STRIPES_W  = STRIPES_W_DEF,
    parameter int OBUF_DEPTH = OBUF_DEPTH_DEF
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rst,
    input  logic                 op_en,
    input  logic [ATOMS_W-1:0]   cfg_atoms,
    input  logic [STRIPES_W-1:0] cfg_stripes,
    nvdla_conv_flow_ctrl_if.slave io,
    output logic                 busy,
    output logic                 done
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CRW  = $clog2(OBUF_DEPTH + 1);

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic            last;
    } ent_t;

    state_e               state_q, state_d;
    logic [ATOMS_W-1:0]   atoms_q, atoms_d, atom_cnt_q, atom_cnt_d;
    logic [STRIPES_W-1:0] stripes_q, stripes_d, stripe_cnt_q, stripe_cnt_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [CRW-1:0]       credit_q, credit_d;
    logic                 done_q, done_d;

    logic ready, fire, fire_last, pop, push_v, obuf_empty, obuf_full;
    ent_t new_e, push_e, head_e;

    // Counts are zero-based, so a config of 0 wraps to the all-ones last index (2^W ops).
    wire [ATOMS_W-1:0]   atom_last   = atoms_q - ATOMS_W'(1);
    wire [STRIPES_W-1:0] stripe_last = stripes_q - STRIPES_W'(1);

    assign ready = (state_q == ST_RUN) && ((atom_cnt_q != atom_last) || (credit_q != '0));
    assign fire  = io.data_i_valid && io.weight_i_valid && ready;
    assign pop   = io.cacc2sdp_valid && io.sdp2cacc_ready;

    always_comb begin
        state_d      = state_q;
        atoms_d      = atoms_q;
        stripes_d    = stripes_q;
        atom_cnt_d   = atom_cnt_q;
        stripe_cnt_d = stripe_cnt_q;
        ch_d         = ch_q;
        done_d       = 1'b0;
        fire_last    = 1'b0;
        new_e.ch     = ch_q;
        new_e.last   = (stripe_cnt_q == stripe_last);
        unique case (state_q)
            ST_IDLE: begin
                if (op_en) begin
                    atoms_d      = cfg_atoms;
                    stripes_d    = cfg_stripes;
                    atom_cnt_d   = '0;
                    stripe_cnt_d = '0;
                    ch_d         = '0;
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fire) begin
                    if (atom_cnt_q == atom_last) begin
                        fire_last    = 1'b1;
                        atom_cnt_d   = '0;
                        stripe_cnt_d = stripe_cnt_q + STRIPES_W'(1);
                        ch_d         = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
                        if (new_e.last) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        atom_cnt_d = atom_cnt_q + ATOMS_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Leave as soon as the final pop returns the last outstanding credit.
                if (pop ? (credit_q == CRW'(OBUF_DEPTH - 1)) : (credit_q == CRW'(OBUF_DEPTH))) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        credit_d = credit_q;
        if (fire_last && !pop) begin
            credit_d = credit_q - CRW'(1);
        end else if (!fire_last && pop) begin
            credit_d = credit_q + CRW'(1);
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_q      <= ST_IDLE;
            atoms_q      <= '0;
            stripes_q    <= '0;
            atom_cnt_q   <= '0;
            stripe_cnt_q <= '0;
            ch_q         <= '0;
            credit_q     <= CRW'(OBUF_DEPTH);
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            atoms_q      <= atoms_d;
            stripes_q    <= stripes_d;
            atom_cnt_q   <= atom_cnt_d;
            stripe_cnt_q <= stripe_cnt_d;
            ch_q         <= ch_d;
            credit_q     <= credit_d;
            done_q       <= done_d;
        end
    end

    generate
        if (MAC_LAT == 1) begin : g_direct
            assign push_v = fire_last;
            assign push_e = new_e;
        end else begin : g_pipe
            logic [MAC_LAT-2:0] pv_q, pv_d;
            ent_t               pe_q [MAC_LAT-1];
            ent_t               pe_d [MAC_LAT-1];

            always_comb begin
                pv_d[0] = fire_last;
                pe_d[0] = new_e;
                for (int i = 1; i < MAC_LAT - 1; i++) begin
                    pv_d[i] = pv_q[i-1];
                    pe_d[i] = pe_q[i-1];
                end
            end

            always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
                if (nvdla_core_rst) begin
                    pv_q <= '0;
                    for (int i = 0; i < MAC_LAT - 1; i++) begin
                        pe_q[i] <= '0;
                    end
                end else begin
                    pv_q <= pv_d;
                    pe_q <= pe_d;
                end
            end

            assign push_v = pv_q[MAC_LAT-2];
            assign push_e = pe_q[MAC_LAT-2];
        end
    endgenerate

    nvdla_conv_obuf #(
        .DEPTH   (OBUF_DEPTH),
        .entry_t (ent_t)
    ) u_obuf (
        .clk       (nvdla_core_clk),
        .rst       (nvdla_core_rst),
        .push      (push_v),
        .push_data (push_e),
        .pop       (pop),
        .head      (head_e),
        .empty     (obuf_empty),
        .full      (obuf_full)
    );

    assign io.data_i_ready   = ready;
    assign io.weight_i_ready = ready;
    assign io.cacc2sdp_valid = !obuf_empty;
    assign io.cacc2sdp_ch    = head_e.ch;
    assign io.cacc2sdp_last  = head_e.last;
    assign busy              = (state_q != ST_IDLE);
    assign done              = done_q;

    a_credit_max: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        credit_q <= CRW'(OBUF_DEPTH));
    a_obuf_no_overflow: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        !(push_v && obuf_full));

endmodule

// File: tb/tb_nvdla_conv_flow_ctrl.sv
// tb/tb_nvdla_conv_flow_ctrl.sv - scoreboard bench for nvdla_conv_flow_ctrl
module tb_nvdla_conv_flow_ctrl;
    import nvdla_conv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_en = 1'b0;
    logic [7:0]  cfg_atoms = '0;
    logic [15:0] cfg_stripes = '0;
    logic        busy, done;

    nvdla_conv_flow_ctrl_if #(.CH_W(1)) io ();

    nvdla_conv_flow_ctrl #(
        .NUM_CH(2), .MAC_LAT(3), .ATOMS_W(8), .STRIPES_W(16), .OBUF_DEPTH(4)
    ) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .op_en          (op_en),
        .cfg_atoms      (cfg_atoms),
        .cfg_stripes    (cfg_stripes),
        .io             (io.slave),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int last;
    } exp_t;

    exp_t sb[$];
    int   pop_cyc[$];
    int   cyc = 0;
    int   fires = 0, pops = 0, done_cnt = 0, done_cyc = -1;
    int   n_chk = 0, n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (io.data_i_valid && io.weight_i_valid && io.data_i_ready) fires++;
            if (io.cacc2sdp_valid && io.sdp2cacc_ready) begin
                pops++;
                pop_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("result_ch", int'(io.cacc2sdp_ch), e.ch);
                    check("result_last", int'(io.cacc2sdp_last), e.last);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_low_at_done", int'(busy), 0);
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_op(input int a, input int s, output int t0);
        @(posedge clk);
        #1;
        cfg_atoms   = 8'(a);
        cfg_stripes = 16'(s);
        op_en       = 1'b1;
        t0          = cyc;
        @(posedge clk);
        #1;
        op_en = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int d0;
        int ok;
        d0 = done_cnt;
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt != d0) begin
                ok = 1;
                break;
            end
        end
        check("done_within_budget", ok, 1);
    endtask

    task automatic push_exp(input int ch, input int last);
        exp_t e;
        e.ch   = ch;
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, int'(io.cacc2sdp_valid), 0);
        check({tag, "_data_ready"}, int'(io.data_i_ready), 0);
        check({tag, "_weight_ready"}, int'(io.weight_i_ready), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_ch"}, int'(io.cacc2sdp_ch), 0);
        check({tag, "_last"}, int'(io.cacc2sdp_last), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, f0, p0;
        io.data_i_valid   = 1'b0;
        io.weight_i_valid = 1'b0;
        io.sdp2cacc_ready = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(2);

        // basic flow: 4 atoms x 3 stripes, free-running handshakes
        push_exp(0, 0); push_exp(1, 0); push_exp(0, 1);
        pop_cyc.delete();
        io.data_i_valid = 1'b1; io.weight_i_valid = 1'b1; io.sdp2cacc_ready = 1'b1;
        start_op(4, 3, t0);
        wait_done(100);
        check("basic_pop_count", pop_cyc.size(), 3);
        if (pop_cyc.size() == 3) begin
            check("basic_pop0_cycle", pop_cyc[0], t0 + 7);
            check("basic_pop1_cycle", pop_cyc[1], t0 + 11);
            check("basic_pop2_cycle", pop_cyc[2], t0 + 15);
        end
        check("basic_done_cycle", done_cyc, t0 + 16);
        tick(3);
        check("basic_done_single_pulse", done_cnt, 1);
        io.data_i_valid = 1'b0; io.weight_i_valid = 1'b0;

        // back-pressure: 1 atom x 6 stripes with SDP stalled
        for (int i = 0; i < 6; i++) push_exp(i % 2, (i == 5) ? 1 : 0);
        io.sdp2cacc_ready = 1'b0;
        io.data_i_valid = 1'b1; io.weight_i_valid = 1'b1;
        f0 = fires; p0 = pops;
        start_op(1, 6, t0);
        tick(20);
        check("bp_fires_credit_limited", fires - f0, 4);
        check("bp_data_ready_low", int'(io.data_i_ready), 0);
        check("bp_weight_ready_low", int'(io.weight_i_ready), 0);
        io.sdp2cacc_ready = 1'b1;
        tick(1);
        io.sdp2cacc_ready = 1'b0;
        tick(10);
        check("bp_fires_after_one_pop", fires - f0, 5);
        check("bp_single_pop", pops - p0, 1);
        io.sdp2cacc_ready = 1'b1;
        wait_done(100);
        check("bp_total_results", pops - p0, 6);
        check("bp_scoreboard_empty", sb.size(), 0);
        io.data_i_valid = 1'b0; io.weight_i_valid = 1'b0;

        // unbalanced inputs: data alone consumes nothing
        push_exp(0, 1);
        f0 = fires; p0 = pops;
        io.data_i_valid = 1'b1;
        start_op(2, 1, t0);
        tick(10);
        check("unbal_no_fire", fires - f0, 0);
        check("unbal_ready_held", int'(io.data_i_ready), 1);
        io.weight_i_valid = 1'b1;
        tick(1);
        check("unbal_fire_same_cycle", fires - f0, 1);
        wait_done(50);
        check("unbal_results", pops - p0, 1);
        io.data_i_valid = 1'b0; io.weight_i_valid = 1'b0;

        // credit boundary: pop at credit 0 blocks, pop at credit 1 holds
        for (int i = 0; i < 8; i++) push_exp(i % 2, (i == 7) ? 1 : 0);
        io.sdp2cacc_ready = 1'b0;
        io.data_i_valid = 1'b1; io.weight_i_valid = 1'b1;
        f0 = fires; p0 = pops;
        start_op(1, 8, t0);
        tick(15);
        check("credit_full_fires", fires - f0, 4);
        io.sdp2cacc_ready = 1'b1;
        tick(1);
        check("credit0_pop_blocks_fire", fires - f0, 4);
        tick(1);
        io.sdp2cacc_ready = 1'b0;
        check("credit1_fire_with_pop", fires - f0, 5);
        tick(1);
        check("credit1_held_then_fire", fires - f0, 6);
        tick(5);
        check("credit_exhausted_again", fires - f0, 6);
        check("credit_pops", pops - p0, 2);
        io.sdp2cacc_ready = 1'b1;
        wait_done(100);
        check("credit_total_results", pops - p0, 8);
        check("credit_scoreboard_empty", sb.size(), 0);
        io.data_i_valid = 1'b0; io.weight_i_valid = 1'b0;

        // reset mid-operation with 1 buffered and 2 in the MAC pipeline
        io.sdp2cacc_ready = 1'b0;
        io.data_i_valid = 1'b1; io.weight_i_valid = 1'b1;
        start_op(1, 8, t0);
        tick(3);
        check("midop_valid_before_reset", int'(io.cacc2sdp_valid), 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midop_reset");
        sb.delete();
        tick(1);
        rst = 1'b0;
        push_exp(0, 1);
        io.sdp2cacc_ready = 1'b1;
        p0 = pops;
        start_op(2, 1, t0);
        wait_done(50);
        tick(5);
        check("post_reset_results", pops - p0, 1);
        check("post_reset_scoreboard_empty", sb.size(), 0);

        // zero atom config means 256 ops; stray op_en in RUN is ignored
        push_exp(0, 1);
        f0 = fires; p0 = pops;
        start_op(0, 1, t0);
        tick(20);
        cfg_atoms = 8'd2; cfg_stripes = 16'd3; op_en = 1'b1;
        tick(1);
        op_en = 1'b0;
        wait_done(400);
        check("zero_cfg_fires", fires - f0, 256);
        check("zero_cfg_done_cycle", done_cyc, t0 + 260);
        tick(5);
        check("zero_cfg_results", pops - p0, 1);
        check("zero_cfg_idle", int'(busy), 0);
        io.data_i_valid = 1'b0; io.weight_i_valid = 1'b0;

        check("done_pulses_total", done_cnt, 6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
